// File: rtl/pixel_lane_packer.sv
// pixel_lane_packer
// Packs a serial valid/ready stream of W-bit pixels into 4-lane parallel words
// for the sub-pixel delay/interpolator datapath. Each word carries a one-cycle
// valid strobe, a 10-bit word index within the line and a last-of-line flag.
// A partial group at end-of-line is completed by replicating the edge pixel.
// After each line's final word, input is held off for GAP_CYC cycles so the
// downstream pipeline can drain.
//
// Ports:
//   clk                      clock
//   reset                    asynchronous active-low reset
//   pix_in / pix_in_v        serial pixel and its valid
//   pix_sol / pix_eol        start/end-of-line, qualified by acceptance
//   pix_in_ready             registered; high in IDLE and PACK
//   sample_out0..3           lane words, lane 0 = earliest pixel (held)
//   sample_out_v             one-cycle strobe per emitted word
//   clk_cnt                  word index within the line (wraps 1023 -> 0)
//   line_last                high with the final word of a line
//   sol_err                  one-cycle pulse on a start-of-line protocol error
//
// Build option: define PACK_ZERO_PAD_EN to fill the lanes above the eol
// pixel with zero instead of replicating the edge pixel.

module pixel_lane_packer #(
    parameter int L       = 4,
    parameter int W       = 14,
    parameter int GAP_CYC = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] pix_in,
    input  logic         pix_in_v,
    input  logic         pix_sol,
    input  logic         pix_eol,
    output logic         pix_in_ready,
    output logic [W-1:0] sample_out0,
    output logic [W-1:0] sample_out1,
    output logic [W-1:0] sample_out2,
    output logic [W-1:0] sample_out3,
    output logic         sample_out_v,
    output logic [9:0]   clk_cnt,
    output logic         line_last,
    output logic         sol_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PACK = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYC - 1);

    state_t         state_q;
    logic [1:0]     lane_q;
    logic [9:0]     word_cnt_q;
    logic [3:0]     gap_cnt_q;
    logic [W-1:0]   buf_q [L];

    logic           accept_s;
    logic           start_s;
    logic           take_s;
    logic           emit_s;
    logic           err_s;
    logic [1:0]     eff_lane_s;
    logic [9:0]     wc_base_s;
    logic [W-1:0]   fill_s;
    logic [W-1:0]   word_s [L];

    // Acceptance decode and assembly of the word that would be emitted now.
    always_comb begin
        accept_s = pix_in_v & pix_in_ready;
        start_s  = accept_s & pix_sol;
        // Pixels accepted in IDLE without sol are dropped, not packed.
        take_s   = accept_s & (pix_sol | (state_q == ST_PACK));
        // sol outside IDLE abandons the partial group; sol missing in IDLE is dropped.
        if (pix_sol) begin
            err_s = accept_s & (state_q == ST_PACK);
        end else begin
            err_s = accept_s & (state_q == ST_IDLE);
        end
        if (start_s) begin
            eff_lane_s = 2'd0;
            wc_base_s  = 10'd0;
        end else begin
            eff_lane_s = lane_q;
            wc_base_s  = word_cnt_q;
        end
        emit_s = take_s & ((eff_lane_s == 2'd3) | pix_eol);
`ifdef PACK_ZERO_PAD_EN
        fill_s = '0;
`else
        fill_s = pix_in;
`endif
        for (int i = 0; i < L; i++) begin
            if (2'(i) == eff_lane_s) begin
                word_s[i] = pix_in;
            end else if (2'(i) > eff_lane_s) begin
                word_s[i] = fill_s;
            end else begin
                word_s[i] = buf_q[i];
            end
        end
    end

    // Packer state machine with registered handshake and lane outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            lane_q       <= 2'd0;
            word_cnt_q   <= 10'd0;
            gap_cnt_q    <= 4'd0;
            for (int i = 0; i < L; i++) begin
                buf_q[i] <= '0;
            end
            pix_in_ready <= 1'b0;
            sample_out0  <= '0;
            sample_out1  <= '0;
            sample_out2  <= '0;
            sample_out3  <= '0;
            sample_out_v <= 1'b0;
            clk_cnt      <= 10'd0;
            line_last    <= 1'b0;
            sol_err      <= 1'b0;
        end else begin
            sample_out_v <= 1'b0;
            line_last    <= 1'b0;
            sol_err      <= err_s;
            case (state_q)
                ST_IDLE, ST_PACK: begin
                    pix_in_ready <= 1'b1;
                    if (take_s) begin
                        buf_q[eff_lane_s] <= pix_in;
                        if (emit_s) begin
                            sample_out0  <= word_s[0];
                            sample_out1  <= word_s[1];
                            sample_out2  <= word_s[2];
                            sample_out3  <= word_s[3];
                            sample_out_v <= 1'b1;
                            clk_cnt      <= wc_base_s;
                            line_last    <= pix_eol;
                            word_cnt_q   <= wc_base_s + 10'd1;
                        end else begin
                            word_cnt_q   <= wc_base_s;
                        end
                        if (pix_eol) begin
                            state_q      <= ST_GAP;
                            pix_in_ready <= 1'b0;
                            gap_cnt_q    <= 4'd0;
                            lane_q       <= 2'd0;
                        end else begin
                            state_q      <= ST_PACK;
                            lane_q       <= eff_lane_s + 2'd1;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_q      <= ST_IDLE;
                        pix_in_ready <= 1'b1;
                        gap_cnt_q    <= 4'd0;
                    end else begin
                        gap_cnt_q    <= gap_cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    pix_in_ready <= 1'b1;
                    lane_q       <= 2'd0;
                    gap_cnt_q    <= 4'd0;
                end
            endcase
        end
    end

endmodule
